// File: rtl/csa_resolver_seq.sv
// Sequential carry-save resolver: adds a sum/carry vector pair one
// CHUNK-bit slice per cycle behind valid/ready handshakes.
module csa_resolver_seq #(
  parameter int W     = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] sum_in,
  input  logic [W-1:0] carry_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   result,
  output logic         busy
);

  localparam int NCHUNK = W / CHUNK;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [NCHUNK-1:0][CHUNK-1:0] s_q;
  logic [NCHUNK-1:0][CHUNK-1:0] c_q;
  logic [NCHUNK-1:0][CHUNK-1:0] res_lo;
  logic                         res_hi;
  logic                         cy;
  logic [CW-1:0]                cnt;
  logic [CHUNK:0]               slice;
  logic                         accept;
  logic                         last;

  assign accept = (state == IDLE) && in_valid;
  assign last   = (cnt == LAST);

  // One ripple slice: the only arithmetic on the critical path.
  assign slice = {1'b0, s_q[cnt]}
               + {1'b0, c_q[cnt]}
               + {{CHUNK{1'b0}}, cy};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ADD;
      end
      ADD: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q    <= '0;
      c_q    <= '0;
      res_lo <= '0;
      res_hi <= 1'b0;
      cy     <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      s_q <= sum_in;
      c_q <= carry_in;
      cy  <= 1'b0;
      cnt <= '0;
    end else if (state == ADD) begin
      res_lo[cnt] <= slice[CHUNK-1:0];
      cy          <= slice[CHUNK];
      if (last) begin
        res_hi <= slice[CHUNK];
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign result = {res_hi, res_lo};

endmodule

// File: tb/tb_csa_resolver_seq.sv
// Bench for csa_resolver_seq: directed scenarios plus randomized
// traffic on three width/chunk configurations against a wide adder.
module tb_csa_resolver_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic in_valid  [3];
  logic in_ready  [3];
  logic out_valid [3];
  logic out_ready [3];
  logic busy      [3];

  logic [31:0] sum0, carry0;
  logic [15:0] sum1, carry1;
  logic [63:0] sum2, carry2;
  logic [32:0] res0;
  logic [16:0] res1;
  logic [64:0] res2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  csa_resolver_seq #(.W(32), .CHUNK(8)) u_dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .sum_in(sum0), .carry_in(carry0),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .result(res0), .busy(busy[0])
  );

  csa_resolver_seq #(.W(16), .CHUNK(4)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .sum_in(sum1), .carry_in(carry1),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .result(res1), .busy(busy[1])
  );

  csa_resolver_seq #(.W(64), .CHUNK(16)) u_dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .sum_in(sum2), .carry_in(carry2),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .result(res2), .busy(busy[2])
  );

  function automatic logic [64:0] get_res(input int sel);
    case (sel)
      0:       return {32'b0, res0};
      1:       return {48'b0, res1};
      default: return res2;
    endcase
  endfunction

  function automatic logic [63:0] wmask(input int sel);
    case (sel)
      0:       return 64'h0000_0000_FFFF_FFFF;
      1:       return 64'h0000_0000_0000_FFFF;
      default: return '1;
    endcase
  endfunction

  // Reference: exact unsigned sum of the two masked operands.
  function automatic logic [64:0] ref_sum(input int sel,
                                          input logic [63:0] a,
                                          input logic [63:0] b);
    logic [64:0] wa, wb;
    wa = {1'b0, a & wmask(sel)};
    wb = {1'b0, b & wmask(sel)};
    return wa + wb;
  endfunction

  task automatic drive(input int sel, input logic v,
                       input logic [63:0] a, input logic [63:0] b);
    case (sel)
      0: begin
        in_valid[0] = v; sum0 = a[31:0]; carry0 = b[31:0];
      end
      1: begin
        in_valid[1] = v; sum1 = a[15:0]; carry1 = b[15:0];
      end
      default: begin
        in_valid[2] = v; sum2 = a; carry2 = b;
      end
    endcase
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge after
  // the result handshake. lat counts edges from accept to out_valid.
  task automatic run_op(input int sel,
                        input logic [63:0] a, input logic [63:0] b,
                        input int stall,
                        output int lat, output logic [64:0] res,
                        output logic vld_after);
    int n;
    n = 0;
    drive(sel, 1'b1, a, b);
    while (!in_ready[sel] && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    drive(sel, 1'b0, '0, '0);
    lat = 0;
    while (!out_valid[sel] && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    repeat (stall) @(negedge clk);
    res = get_res(sel);
    out_ready[sel] = 1'b1;
    @(negedge clk);
    out_ready[sel] = 1'b0;
    vld_after = out_valid[sel];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    vectors++;
    if (in_ready[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready[0]);
    end
    vectors++;
    if (out_valid[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out_valid: got %b want 0", out_valid[0]);
    end
    vectors++;
    if (res0 !== 33'h0) begin
      miscompares++;
      $display("FAIL reset_result: got %h want 0", res0);
    end
    vectors++;
    if (busy[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy: got %b want 0", busy[0]);
    end
    drive(0, 1'b1, 64'h5, 64'h6);
    repeat (2) @(negedge clk);
    vectors++;
    if (busy[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_no_sample: busy %b want 0", busy[0]);
    end
    drive(0, 1'b0, '0, '0);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    logic [64:0] r;
    logic v;
    run_op(0, 64'hFF, 64'h1, 0, lat, r, v);
    vectors++;
    if (r !== 65'h100) begin
      miscompares++;
      $display("FAIL basic_result: got %h want 100", r);
    end
    vectors++;
    if (lat !== 4) begin
      miscompares++;
      $display("FAIL basic_latency: got %0d want 4", lat);
    end
    vectors++;
    if (v !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_valid_1cyc: out_valid %b want 0", v);
    end
  endtask

  task automatic test_carry_chain();
    int lat;
    logic [64:0] r;
    logic v;
    run_op(0, 64'hFFFF_FFFF, 64'h1, 1, lat, r, v);
    vectors++;
    if (r !== 65'h1_0000_0000) begin
      miscompares++;
      $display("FAIL carry_chain: got %h want 100000000", r);
    end
  endtask

  task automatic test_backpressure();
    int n;
    drive(0, 1'b1, 64'h1234_5678, 64'h0F0F_0F0F);
    @(negedge clk);
    drive(0, 1'b1, 64'h1111_1111, 64'h2222_2222);
    n = 0;
    while (!out_valid[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (res0 !== 33'h0_2143_6587) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got %h want 021436587", i, res0);
      end
      vectors++;
      if (in_ready[0] !== 1'b0 || busy[0] !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_flags[%0d]: rdy %b busy %b want 0 1",
                 i, in_ready[0], busy[0]);
      end
      @(negedge clk);
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    vectors++;
    if (in_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_release: rdy %b busy %b want 1 0",
               in_ready[0], busy[0]);
    end
    @(negedge clk);
    drive(0, 1'b0, '0, '0);
    vectors++;
    if (busy[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_next_accept: busy %b want 1", busy[0]);
    end
    n = 0;
    while (!out_valid[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (res0 !== 33'h0_3333_3333) begin
      miscompares++;
      $display("FAIL bp_next_result: got %h want 033333333", res0);
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [64:0] r;
    logic v;
    drive(0, 1'b1, 64'hDEAD_BEEF, 64'h1357_9BDF);
    @(negedge clk);
    drive(0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_hs: valid %b rdy %b want 0 1",
               out_valid[0], in_ready[0]);
    end
    vectors++;
    if (res0 !== 33'h0 || busy[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_state: result %h busy %b want 0 0",
               res0, busy[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(0, 64'h8000_0000, 64'h8000_0000, 0, lat, r, v);
    vectors++;
    if (r !== 65'h1_0000_0000) begin
      miscompares++;
      $display("FAIL rstmid_next: got %h want 100000000", r);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a [3];
    logic [63:0] b [3];
    logic [64:0] exp_q [$];
    int acc [$];
    int cyc, idx, got;
    logic [64:0] e;
    for (int i = 0; i < 3; i++) begin
      a[i] = {32'b0, $urandom};
      b[i] = {32'b0, $urandom};
    end
    idx = 0;
    got = 0;
    cyc = 0;
    out_ready[0] = 1'b1;
    drive(0, 1'b1, a[0], b[0]);
    while (got < 3 && cyc < 100) begin
      if (out_valid[0] && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (get_res(0) !== e) begin
          miscompares++;
          $display("FAIL b2b_result[%0d]: got %h want %h",
                   got, get_res(0), e);
        end
        got++;
      end
      if (in_ready[0] && idx < 3) begin
        acc.push_back(cyc);
        exp_q.push_back(ref_sum(0, a[idx], b[idx]));
        idx++;
      end
      @(negedge clk);
      cyc++;
      if (idx < 3) drive(0, 1'b1, a[idx], b[idx]);
      else         drive(0, 1'b0, '0, '0);
    end
    out_ready[0] = 1'b0;
    vectors++;
    if (got !== 3) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d results want 3", got);
    end
    for (int i = 0; i + 1 < acc.size(); i++) begin
      vectors++;
      if (acc[i+1] - acc[i] !== 6) begin
        miscompares++;
        $display("FAIL b2b_spacing[%0d]: got %0d want 6",
                 i, acc[i+1] - acc[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_random(input int sel, input int n);
    logic [63:0] a, b;
    logic [64:0] r, e;
    int lat;
    logic v;
    for (int i = 0; i < n; i++) begin
      a = {$urandom, $urandom} & wmask(sel);
      b = {$urandom, $urandom} & wmask(sel);
      if ($urandom_range(0, 7) == 0) a = wmask(sel);
      if ($urandom_range(0, 7) == 0) b = wmask(sel);
      e = ref_sum(sel, a, b);
      run_op(sel, a, b, $urandom_range(0, 3), lat, r, v);
      vectors++;
      if (r !== e || lat !== 4 || v !== 1'b0) begin
        miscompares++;
        $display("FAIL rand%0d[%0d]: got %h lat %0d want %h lat 4",
                 sel, i, r, lat, e);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      out_ready[i] = 1'b0;
      drive(i, 1'b0, '0, '0);
    end
    test_reset();
    @(negedge clk);
    test_basic();
    test_carry_chain();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random(0, 2000);
    test_random(1, 1000);
    test_random(2, 1000);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
